sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter_pkg.sv | 16 +
 rtl/sdram_arbiter_if.sv | 28 ++
 rtl/sdram_arb_id_fifo.sv | 61 ++++++
 rtl/sdram_arbiter.sv | 158 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_arbiter_pkg.sv
// Shared defaults and types for the two-requester SDRAM arbiter.
package sdram_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF   = 22;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned MAX_PEND_DEF = 8;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  // 0 = filter read port, 1 = filter write-back port
  typedef logic [0:0] req_id_t;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Avalon-MM single-word bus bundle. The master modport is the command issuer.
interface sdram_arbiter_if
  import sdram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/sdram_arb_id_fifo.sv
// Requester-ID FIFO tracking issue order of outstanding reads. Depth must be a power of 2.
module sdram_arb_id_fifo
  import sdram_arbiter_pkg::*;
#(
  parameter int unsigned Depth = MAX_PEND_DEF,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  req_id_t       id_in,
  output req_id_t       id_out,
  output logic [PtrW:0] count,
  output logic          empty,
  output logic          full
);

  req_id_t         mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign empty  = (count_q == '0);
  assign full   = (count_q == (PtrW + 1)'(Depth));
  assign count  = count_q;
  assign id_out = mem_q[rd_ptr_q];

  // Next-state pointers and occupancy; simultaneous push/pop leaves count unchanged
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care while unoccupied so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= id_in;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master between the filter read (r0)
// and write-back (r1) ports, with in-order read response routing.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_PEND = MAX_PEND_DEF
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  sdram_arbiter_if.slave           r0,
  sdram_arbiter_if.slave           r1,
  sdram_arbiter_if.master          m,
  output logic [$clog2(MAX_PEND):0] pend_count,
  output logic                     err_underflow
);

  state_e              state_q, state_d;
  req_id_t             grant_q, grant_d, last_grant_q, last_grant_d, win;
  logic                m_read_q, m_read_d, m_write_q, m_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, sel_addr;
  logic [DATA_W-1:0]   wdata_q, wdata_d, sel_wdata;
  logic [DATA_W/8-1:0] be_q, be_d, sel_be;
  logic                sel_read, sel_write, elig0, elig1;
  logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                err_q, err_d;
  logic                accept, push, pop, fifo_empty, fifo_full;
  req_id_t             pop_id;

  // Eligibility, round-robin winner and winner's command mux (write beats read)
  always_comb begin
    elig0 = r0.write | (r0.read & ~fifo_full);
    elig1 = r1.write | (r1.read & ~fifo_full);
    win   = (elig0 & elig1) ? ~last_grant_q : elig1;
    if (win == 1'b1) begin
      sel_write = r1.write;
      sel_read  = r1.read & ~r1.write;
      sel_addr  = r1.address;
      sel_wdata = r1.writedata;
      sel_be    = r1.byteenable;
    end else begin
      sel_write = r0.write;
      sel_read  = r0.read & ~r0.write;
      sel_addr  = r0.address;
      sel_wdata = r0.writedata;
      sel_be    = r0.byteenable;
    end
  end

  assign accept = (state_q == StBusy) & ~m.waitrequest;
  assign push   = accept & m_read_q;

  // IDLE/BUSY control: latch the winner, hold m_* until the controller accepts
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    m_read_d     = m_read_q;
    m_write_d    = m_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    case (state_q)
      StIdle: begin
        if (elig0 | elig1) begin
          state_d      = StBusy;
          grant_d      = win;
          last_grant_d = win;
          m_read_d     = sel_read;
          m_write_d    = sel_write;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          be_d         = sel_be;
        end
      end
      default: begin
        if (!m.waitrequest) begin
          state_d   = StIdle;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
        end
      end
    endcase
  end

  // Response routing to the oldest outstanding requester; stray responses are dropped
  always_comb begin
    pop       = m.readdatavalid & ~fifo_empty;
    err_d     = err_q | (m.readdatavalid & fifo_empty);
    rvalid0_d = pop & (pop_id == 1'b0);
    rvalid1_d = pop & (pop_id == 1'b1);
    rdata0_d  = rvalid0_d ? m.readdata : rdata0_q;
    rdata1_d  = rvalid1_d ? m.readdata : rdata1_q;
  end

  // All arbiter state; reset abandons any transfer in flight
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      m_read_q     <= 1'b0;
      m_write_q    <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      m_read_q     <= m_read_d;
      m_write_q    <= m_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      err_q        <= err_d;
    end
  end

  sdram_arb_id_fifo #(
    .Depth (MAX_PEND)
  ) u_id_fifo (
    .clk    (clk_clk),
    .rst    (reset_reset),
    .push   (push),
    .pop    (pop),
    .id_in  (grant_q),
    .id_out (pop_id),
    .count  (pend_count),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  assign m.address        = addr_q;
  assign m.read           = m_read_q;
  assign m.write          = m_write_q;
  assign m.writedata      = wdata_q;
  assign m.byteenable     = be_q;
  assign r0.waitrequest   = ~(accept & (grant_q == 1'b0));
  assign r1.waitrequest   = ~(accept & (grant_q == 1'b1));
  assign r0.readdata      = rdata0_q;
  assign r1.readdata      = rdata1_q;
  assign r0.readdatavalid = rvalid0_q;
  assign r1.readdatavalid = rvalid1_q;
  assign err_underflow    = err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter.
module tb_sdram_arbiter;

  logic       clk;
  logic       reset_reset;
  logic [3:0] pend_count;
  logic       err_underflow;
  int         n_chk;
  int         n_pass;

  sdram_arbiter_if #(.ADDR_W(22), .DATA_W(32)) r0_if ();
  sdram_arbiter_if #(.ADDR_W(22), .DATA_W(32)) r1_if ();
  sdram_arbiter_if #(.ADDR_W(22), .DATA_W(32)) m_if ();

  sdram_arbiter #(
    .ADDR_W   (22),
    .DATA_W   (32),
    .MAX_PEND (8)
  ) dut (
    .clk_clk       (clk),
    .reset_reset   (reset_reset),
    .r0            (r0_if),
    .r1            (r1_if),
    .m             (m_if),
    .pend_count    (pend_count),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    r0_if.read = 0; r0_if.write = 0; r0_if.address = '0; r0_if.writedata = '0;
    r0_if.byteenable = 4'hF;
    r1_if.read = 0; r1_if.write = 0; r1_if.address = '0; r1_if.writedata = '0;
    r1_if.byteenable = 4'hF;
    m_if.waitrequest = 0; m_if.readdata = '0; m_if.readdatavalid = 0;
  endtask

  task automatic do_reset();
    reset_reset = 1;
    clear_inputs();
    tick();
    tick();
    reset_reset = 0;
  endtask

  // Issue one command from requester req and hold it until accepted.
  task automatic xfer(input int req, input bit wr, input bit rd, input logic [21:0] a,
                      input logic [31:0] d);
    bit   done;
    logic wreq;
    done = 0;
    if (req == 0) begin
      r0_if.write = wr; r0_if.read = rd; r0_if.address = a; r0_if.writedata = d;
    end else begin
      r1_if.write = wr; r1_if.read = rd; r1_if.address = a; r1_if.writedata = d;
    end
    for (int i = 0; i < 32 && !done; i++) begin
      @(negedge clk);
      wreq = (req == 0) ? r0_if.waitrequest : r1_if.waitrequest;
      if (!wreq) done = 1;
    end
    tick();
    r0_if.read = 0; r0_if.write = 0; r1_if.read = 0; r1_if.write = 0;
    if (!done) check("xfer_timeout", 64'd0, 64'd1);
  endtask

  task automatic rsp(input logic [31:0] d);
    m_if.readdatavalid = 1;
    m_if.readdata = d;
    tick();
    m_if.readdatavalid = 0;
  endtask

  initial begin
    int  bad;
    bit  done;
    n_chk = 0;
    n_pass = 0;
    reset_reset = 1;
    clear_inputs();
    #2;
    // Reset values
    check("rst_m_read", m_if.read, 0);
    check("rst_m_write", m_if.write, 0);
    check("rst_m_address", m_if.address, 0);
    check("rst_m_be", m_if.byteenable, 0);
    check("rst_r0_wait", r0_if.waitrequest, 1);
    check("rst_r1_wait", r1_if.waitrequest, 1);
    check("rst_r0_rvalid", r0_if.readdatavalid, 0);
    check("rst_r0_rdata", r0_if.readdata, 0);
    check("rst_pend", pend_count, 0);
    check("rst_err", err_underflow, 0);
    do_reset();

    // Single write, one cycle to m_*
    r0_if.write = 1; r0_if.address = 22'h000010; r0_if.writedata = 32'hDEADBEEF;
    r0_if.byteenable = 4'h5;
    tick();
    check("wr_m_write", m_if.write, 1);
    check("wr_m_read", m_if.read, 0);
    check("wr_m_address", m_if.address, 22'h000010);
    check("wr_m_wdata", m_if.writedata, 32'hDEADBEEF);
    check("wr_m_be", m_if.byteenable, 4'h5);
    check("wr_r0_wait", r0_if.waitrequest, 0);
    check("wr_r1_wait", r1_if.waitrequest, 1);
    tick();
    r0_if.write = 0;
    check("wr_idle_m_write", m_if.write, 0);
    check("wr_pend", pend_count, 0);

    // Read and write together: write is served, nothing pushed
    r1_if.read = 1; r1_if.write = 1; r1_if.address = 22'h000020; r1_if.writedata = 32'h1234;
    tick();
    check("rw_m_write", m_if.write, 1);
    check("rw_m_read", m_if.read, 0);
    tick();
    r1_if.read = 0; r1_if.write = 0;
    check("rw_pend", pend_count, 0);

    // Contention: alternating grants starting with r0
    do_reset();
    r0_if.read = 1; r0_if.address = 22'h40;
    r1_if.write = 1; r1_if.address = 22'h80;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rr%0d_m_read", i), m_if.read, (i % 2 == 0) ? 1 : 0);
      check($sformatf("rr%0d_m_write", i), m_if.write, (i % 2 == 1) ? 1 : 0);
      check($sformatf("rr%0d_addr", i), m_if.address, (i % 2 == 0) ? 22'h40 : 22'h80);
      tick();
    end
    r0_if.read = 0; r1_if.write = 0;
    check("rr_pend", pend_count, 2);

    // In-order response routing
    do_reset();
    xfer(0, 0, 1, 22'h100, 0);
    xfer(1, 0, 1, 22'h200, 0);
    xfer(0, 0, 1, 22'h300, 0);
    check("rt_pend3", pend_count, 3);
    rsp(32'hA);
    check("rt_a_r0v", r0_if.readdatavalid, 1);
    check("rt_a_r0d", r0_if.readdata, 32'hA);
    check("rt_a_r1v", r1_if.readdatavalid, 0);
    rsp(32'hB);
    check("rt_b_r1v", r1_if.readdatavalid, 1);
    check("rt_b_r1d", r1_if.readdata, 32'hB);
    check("rt_b_r0v", r0_if.readdatavalid, 0);
    rsp(32'hC);
    check("rt_c_r0v", r0_if.readdatavalid, 1);
    check("rt_c_r0d", r0_if.readdata, 32'hC);
    check("rt_c_r1v", r1_if.readdatavalid, 0);
    tick();
    check("rt_end_r0v", r0_if.readdatavalid, 0);
    check("rt_pend0", pend_count, 0);
    check("rt_err", err_underflow, 0);

    // Full FIFO: reads stall, writes still pass
    do_reset();
    for (int i = 0; i < 8; i++) xfer(0, 0, 1, 22'(i), 0);
    check("full_pend8", pend_count, 8);
    r0_if.read = 1; r0_if.address = 22'h900;
    r1_if.write = 1; r1_if.address = 22'hA00;
    @(posedge clk);
    @(negedge clk);
    check("full_wr_m_write", m_if.write, 1);
    check("full_wr_addr", m_if.address, 22'hA00);
    check("full_wr_r1_wait", r1_if.waitrequest, 0);
    check("full_wr_r0_wait", r0_if.waitrequest, 1);
    tick();
    r1_if.write = 0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!r0_if.waitrequest || m_if.read) bad++;
    end
    check("full_stall", bad, 0);
    check("full_pend_hold", pend_count, 8);
    @(posedge clk);
    #1;
    rsp(32'h55);
    check("full_rsp_r0v", r0_if.readdatavalid, 1);
    check("full_rsp_r0d", r0_if.readdata, 32'h55);
    check("full_pend7", pend_count, 7);
    done = 0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      if (!r0_if.waitrequest) done = 1;
    end
    check("full_release", done, 1);
    check("full_rel_m_read", m_if.read, 1);
    check("full_rel_addr", m_if.address, 22'h900);
    tick();
    r0_if.read = 0;
    check("full_pend8_again", pend_count, 8);

    // Stall holds m_* stable; reset mid-BUSY; stray response afterwards
    do_reset();
    m_if.waitrequest = 1;
    r1_if.read = 1; r1_if.address = 22'h123; r1_if.byteenable = 4'h3;
    tick();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        r1_if.address = 22'h999;
        r1_if.byteenable = 4'hC;
      end
      if (m_if.read !== 1 || m_if.address !== 22'h123 || m_if.byteenable !== 4'h3 ||
          r1_if.waitrequest !== 1) bad++;
    end
    check("stall_stable", bad, 0);
    @(negedge clk);
    reset_reset = 1;
    #1;
    check("midrst_m_read", m_if.read, 0);
    check("midrst_m_addr", m_if.address, 0);
    check("midrst_r1_wait", r1_if.waitrequest, 1);
    @(posedge clk);
    #1;
    reset_reset = 0;
    r1_if.read = 0;
    m_if.waitrequest = 0;
    rsp(32'h77);
    check("stray_err", err_underflow, 1);
    check("stray_r0v", r0_if.readdatavalid, 0);
    check("stray_r1v", r1_if.readdatavalid, 0);
    check("stray_pend", pend_count, 0);
    tick();
    tick();
    check("stray_err_sticky", err_underflow, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
